// File: rtl/uart_sample_receiver.sv
// UART receiver for "C","H",<'0'..'3'>,<msb>,<lsb> sample frames. It drives four
// signed sample registers, a per-frame strobe and a saturating error counter.
module uart_sample_receiver #(
  parameter int CLK_FREQ  = 12_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int W         = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  output logic signed [W-1:0] sample_out0,
  output logic signed [W-1:0] sample_out1,
  output logic signed [W-1:0] sample_out2,
  output logic signed [W-1:0] sample_out3,
  output logic                sample_valid,
  output logic [1:0]          valid_ch,
  output logic [7:0]          err_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  localparam logic [7:0] ASCII_C = 8'h43;
  localparam logic [7:0] ASCII_H = 8'h48;

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } uart_state_t;

  typedef enum logic [2:0] {
    P_HUNT_C,
    P_EXP_H,
    P_EXP_CH,
    P_EXP_MSB,
    P_EXP_LSB
  } parse_state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer and edge history
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rxs;
  logic rxs_prev;

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= rx;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  // ---------------------------------------------------------------------------
  // UART receive FSM
  // ---------------------------------------------------------------------------
  uart_state_t      uart_state, uart_next;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_next;
  logic [2:0]       bit_cnt, bit_cnt_next;
  logic [7:0]       rx_byte, rx_byte_next;
  logic             byte_valid, byte_valid_next;
  logic             frame_err, frame_err_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      uart_state <= U_IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      uart_state <= uart_next;
      clk_cnt    <= clk_cnt_next;
      bit_cnt    <= bit_cnt_next;
      rx_byte    <= rx_byte_next;
      byte_valid <= byte_valid_next;
      frame_err  <= frame_err_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    uart_next       = uart_state;
    clk_cnt_next    = clk_cnt + CNT_W'(1);
    bit_cnt_next    = bit_cnt;
    rx_byte_next    = rx_byte;
    byte_valid_next = 1'b0;
    frame_err_next  = 1'b0;

    unique case (uart_state)
      U_IDLE: begin
        clk_cnt_next = '0;
        if (rxs_prev && !rxs) begin
          uart_next    = U_START;
          bit_cnt_next = '0;
        end
      end
      U_START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_next = '0;
          uart_next    = rxs ? U_IDLE : U_DATA;
        end
      end
      U_DATA: begin
        if (clk_cnt == FULL_LAST) begin
          clk_cnt_next = '0;
          rx_byte_next = {rxs, rx_byte[7:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) uart_next = U_STOP;
        end
      end
      U_STOP: begin
        // Leave mid stop bit so a back-to-back start edge is not missed.
        if (clk_cnt == FULL_LAST) begin
          clk_cnt_next    = '0;
          uart_next       = U_IDLE;
          byte_valid_next = rxs;
          frame_err_next  = !rxs;
        end
      end
      default: uart_next = U_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame parser
  // ---------------------------------------------------------------------------
  parse_state_t p_state, p_next;
  logic         parse_err;
  logic         latch_ch;
  logic         latch_msb;
  logic         commit;

  always_ff @(posedge clk) begin
    if (rst) p_state <= P_HUNT_C;
    else     p_state <= p_next;
  end

  always_comb begin
    p_next    = p_state;
    parse_err = 1'b0;
    latch_ch  = 1'b0;
    latch_msb = 1'b0;
    commit    = 1'b0;

    if (frame_err) begin
      p_next = P_HUNT_C;
    end else if (byte_valid) begin
      unique case (p_state)
        P_HUNT_C: begin
          if (rx_byte == ASCII_C) p_next = P_EXP_H;
        end
        P_EXP_H: begin
          if (rx_byte == ASCII_H) begin
            p_next = P_EXP_CH;
          end else if (rx_byte != ASCII_C) begin
            p_next    = P_HUNT_C;
            parse_err = 1'b1;
          end
        end
        P_EXP_CH: begin
          // ASCII '0'..'3' share the upper six bits 0011_00.
          if (rx_byte[7:2] == 6'b0011_00) begin
            latch_ch = 1'b1;
            p_next   = P_EXP_MSB;
          end else begin
            p_next    = (rx_byte == ASCII_C) ? P_EXP_H : P_HUNT_C;
            parse_err = 1'b1;
          end
        end
        P_EXP_MSB: begin
          latch_msb = 1'b1;
          p_next    = P_EXP_LSB;
        end
        P_EXP_LSB: begin
          commit = 1'b1;
          p_next = P_HUNT_C;
        end
        default: p_next = P_HUNT_C;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sample registers, strobe and error counter
  // ---------------------------------------------------------------------------
  logic        [1:0]   ch;
  logic        [7:0]   msb;
  logic signed [W-1:0] sample_reg [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      ch           <= '0;
      msb          <= '0;
      valid_ch     <= '0;
      sample_valid <= 1'b0;
      err_count    <= '0;
      // NOTE: the sample array is a handful of flops with visible outputs, not
      // a RAM, so it is reset like any other register.
      for (int i = 0; i < 4; i++) sample_reg[i] <= '0;
    end else begin
      sample_valid <= commit;
      if (latch_ch)  ch  <= rx_byte[1:0];
      if (latch_msb) msb <= rx_byte;
      if (commit) begin
        sample_reg[ch] <= {msb, rx_byte};
        valid_ch       <= ch;
      end
      if ((parse_err || frame_err) && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

  assign sample_out0 = sample_reg[0];
  assign sample_out1 = sample_reg[1];
  assign sample_out2 = sample_reg[2];
  assign sample_out3 = sample_reg[3];

endmodule

// File: tb/tb_uart_sample_receiver.sv
// Directed bench for uart_sample_receiver: UART frames at 104 clk/bit with
// hand-computed expected samples, strobes and error counts.
module tb_uart_sample_receiver;

  localparam int BIT_CLKS = 104;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               rx  = 1'b1;
  logic signed [15:0] sample_out0;
  logic signed [15:0] sample_out1;
  logic signed [15:0] sample_out2;
  logic signed [15:0] sample_out3;
  logic               sample_valid;
  logic [1:0]         valid_ch;
  logic [7:0]         err_count;

  int total = 0;
  int bad   = 0;
  int strobe_count = 0;
  int wide_strobes = 0;
  int base;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  uart_sample_receiver dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .sample_out0  (sample_out0),
    .sample_out1  (sample_out1),
    .sample_out2  (sample_out2),
    .sample_out3  (sample_out3),
    .sample_valid (sample_valid),
    .valid_ch     (valid_ch),
    .err_count    (err_count)
  );

  // Strobe monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (sample_valid) strobe_count++;
    if (sample_valid && prev_valid) wide_strobes++;
    prev_valid = sample_valid;
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bit(input logic level);
    rx = level;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_level = 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_level);
    rx = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h,
                            input logic [7:0] d, input logic [7:0] m,
                            input logic [7:0] l);
    send_byte(c);
    send_byte(h);
    send_byte(d);
    send_byte(m);
    send_byte(l);
    repeat (20) @(negedge clk);
  endtask

  task automatic check_samples(input string tag, input int s0, input int s1,
                               input int s2, input int s3);
    check({tag, "_s0"}, int'(sample_out0), s0);
    check({tag, "_s1"}, int'(sample_out1), s1);
    check({tag, "_s2"}, int'(sample_out2), s2);
    check({tag, "_s3"}, int'(sample_out3), s3);
  endtask

  initial begin
    // Reset state.
    do_reset();
    check_samples("reset", 0, 0, 0, 0);
    check("reset_valid", int'(sample_valid), 0);
    check("reset_ch", int'(valid_ch), 0);
    check("reset_err", int'(err_count), 0);

    // Basic frame on channel 1.
    base = strobe_count;
    send_frame(8'h43, 8'h48, 8'h31, 8'h12, 8'h34);
    check("basic_strobes", strobe_count - base, 1);
    check("basic_ch", int'(valid_ch), 1);
    check_samples("basic", 0, 32'h1234, 0, 0);
    check("basic_err", int'(err_count), 0);

    // Signed extremes on channels 3 and 0.
    do_reset();
    base = strobe_count;
    send_frame(8'h43, 8'h48, 8'h33, 8'h80, 8'h00);
    check("ext_ch3", int'(valid_ch), 3);
    send_frame(8'h43, 8'h48, 8'h30, 8'h7F, 8'hFF);
    check("ext_strobes", strobe_count - base, 2);
    check("ext_ch0", int'(valid_ch), 0);
    check_samples("ext", 32767, 0, 0, -32768);
    check("ext_err", int'(err_count), 0);

    // Bad 'H' then "C" resync inside EXP_H.
    do_reset();
    base = strobe_count;
    send_byte(8'h43);
    send_byte(8'h58);
    send_byte(8'h43);
    send_frame(8'h43, 8'h48, 8'h32, 8'hAB, 8'hCD);
    check("resync_err", int'(err_count), 1);
    check("resync_strobes", strobe_count - base, 1);
    check("resync_ch", int'(valid_ch), 2);
    check_samples("resync", 0, 0, -21555, 0);

    // Bad channel digit, then a valid frame.
    do_reset();
    base = strobe_count;
    send_byte(8'h43);
    send_byte(8'h48);
    send_byte(8'h37);
    check("badch_nostrobe", strobe_count - base, 0);
    check("badch_err", int'(err_count), 1);
    send_frame(8'h43, 8'h48, 8'h30, 8'h55, 8'hAA);
    check("badch_strobes", strobe_count - base, 1);
    check_samples("badch", 32'h55AA, 0, 0, 0);
    check("badch_err_after", int'(err_count), 1);

    // Framing error on the LSB byte, then a good frame.
    do_reset();
    base = strobe_count;
    send_byte(8'h43);
    send_byte(8'h48);
    send_byte(8'h31);
    send_byte(8'h11);
    send_byte(8'h22, 1'b0);
    repeat (3 * BIT_CLKS) @(negedge clk);
    check("ferr_nostrobe", strobe_count - base, 0);
    check("ferr_err", int'(err_count), 1);
    check("ferr_s1", int'(sample_out1), 0);
    send_frame(8'h43, 8'h48, 8'h31, 8'h11, 8'h22);
    check("ferr_strobes", strobe_count - base, 1);
    check("ferr_s1_after", int'(sample_out1), 32'h1122);
    check("ferr_err_after", int'(err_count), 1);

    // 40-cycle glitch: no byte, no error; parser still intact afterwards.
    do_reset();
    base = strobe_count;
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch_err", int'(err_count), 0);
    check("glitch_nostrobe", strobe_count - base, 0);
    send_frame(8'h43, 8'h48, 8'h33, 8'h01, 8'h02);
    check("glitch_s3", int'(sample_out3), 258);
    check("glitch_err_after", int'(err_count), 0);

    // Reset mid-frame clears everything and drops the partial frame.
    do_reset();
    send_frame(8'h43, 8'h48, 8'h32, 8'h11, 8'h11);
    check("midrst_pre_s2", int'(sample_out2), 32'h1111);
    send_byte(8'h43);
    send_byte(8'h48);
    send_byte(8'h32);
    do_reset();
    base = strobe_count;
    send_byte(8'h56);
    send_byte(8'h78);
    repeat (20) @(negedge clk);
    check("midrst_nostrobe", strobe_count - base, 0);
    check_samples("midrst", 0, 0, 0, 0);
    check("midrst_ch", int'(valid_ch), 0);
    check("midrst_err", int'(err_count), 0);

    check("strobe_width", wide_strobes, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
